// File: rtl/mc_stream_nbf_unloader.sv
// mc_stream_nbf_unloader
// Turns manycore remote-store packets into 80-bit NBF records
// {x_cord, y_cord, epa, data} and serializes them low flit first onto a
// narrow stream. On a finish request the stream is closed with an all-ones
// terminator record, after which the block parks in DONE until reset.
module mc_stream_nbf_unloader #(
    parameter int addr_width_p        = 28,
    parameter int data_width_p        = 32,
    parameter int x_cord_width_p      = 6,
    parameter int y_cord_width_p      = 5,
    parameter int load_id_width_p     = 12,
    parameter int stream_data_width_p = 32,
    // Payload field is shared with load-id information, so it is as wide as the larger of the two.
    localparam int payload_width_lp = (data_width_p > load_id_width_p) ? data_width_p : load_id_width_p,
    localparam int packet_width_lp  = addr_width_p + 2 + (data_width_p >> 3) + payload_width_lp
                                      + 2 * (x_cord_width_p + y_cord_width_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [packet_width_lp-1:0]     packet_i,
    input  logic                           v_i,
    output logic                           ready_o,
    input  logic                           finish_i,
    output logic                           done_o,
    output logic                           stream_v_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_ready_i,
    output logic [31:0]                    records_o
);

    localparam int nbf_width_lp     = 80;
    localparam int nbf_num_flits_lp = (nbf_width_lp + stream_data_width_p - 1) / stream_data_width_p;
    localparam int pad_width_lp     = nbf_num_flits_lp * stream_data_width_p;
    localparam int cnt_width_lp     = (nbf_num_flits_lp > 1) ? $clog2(nbf_num_flits_lp) : 1;

    localparam logic [1:0]              op_remote_store_lp = 2'b01;
    localparam logic [cnt_width_lp-1:0] last_cnt_lp        = cnt_width_lp'(nbf_num_flits_lp - 1);

    typedef struct packed {
        logic [addr_width_p-1:0]       addr;
        logic [1:0]                    op;
        logic [(data_width_p>>3)-1:0]  op_ex;
        logic [payload_width_lp-1:0]   payload;
        logic [y_cord_width_p-1:0]     src_y_cord;
        logic [x_cord_width_p-1:0]     src_x_cord;
        logic [y_cord_width_p-1:0]     y_cord;
        logic [x_cord_width_p-1:0]     x_cord;
    } packet_s;

    typedef enum logic [1:0] {IDLE_S, SEND_S, TERM_S, DONE_S} state_e;

    state_e                    state_q, state_n;
    logic [cnt_width_lp-1:0]   cnt_q, cnt_n;
    logic                      fin_pending_q;
    logic [31:0]               records_q;
    logic [pad_width_lp-1:0]   sr_q;

    logic load_rec, load_term, shift_flit, rec_inc;

    packet_s                  pkt;
    logic                     is_store;
    logic                     last_flit;
    logic [nbf_width_lp-1:0]  rec_n;
    logic                     unused_fields;

    assign pkt       = packet_i;
    assign is_store  = (pkt.op == op_remote_store_lp);
    assign last_flit = (cnt_q == last_cnt_lp);

    // Record fields are zero-extended to their fixed NBF widths.
    assign rec_n = {8'(pkt.src_x_cord), 8'(pkt.src_y_cord), 32'(pkt.addr),
                    32'(pkt.payload[data_width_p-1:0])};

    // Routing fields the NBF record does not carry.
    assign unused_fields = ^{pkt.op_ex, pkt.payload, pkt.y_cord, pkt.x_cord};

    assign stream_data_o = sr_q[stream_data_width_p-1:0];
    assign stream_v_o    = (state_q == SEND_S) || (state_q == TERM_S);
    assign done_o        = (state_q == DONE_S);
    assign records_o     = records_q;

    // State, flit counter, finish latch and record counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE_S;
            cnt_q         <= '0;
            fin_pending_q <= 1'b0;
            records_q     <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            records_q <= records_q + {31'd0, rec_inc};
            if (finish_i && state_q != DONE_S)
                fin_pending_q <= 1'b1;
        end
    end

    // Flit shift register: low W bits are the flit on the wire. Padding above
    // bit 79 is zero for data records; the terminator is all ones and never shifts.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            sr_q <= '0;
        else if (load_rec)
            sr_q <= pad_width_lp'(rec_n);
        else if (load_term)
            sr_q <= '1;
        else if (shift_flit)
            sr_q <= sr_q >> stream_data_width_p;
    end

    // Next state, flit sequencing and packet-side ready.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        ready_o    = 1'b0;
        load_rec   = 1'b0;
        load_term  = 1'b0;
        shift_flit = 1'b0;
        rec_inc    = 1'b0;
        case (state_q)
            IDLE_S: begin
                ready_o = ~fin_pending_q;
                if (fin_pending_q) begin
                    state_n   = TERM_S;
                    cnt_n     = '0;
                    load_term = 1'b1;
                end else if (v_i && is_store) begin
                    state_n  = SEND_S;
                    cnt_n    = '0;
                    load_rec = 1'b1;
                end
            end
            SEND_S: begin
                if (stream_ready_i) begin
                    if (last_flit) begin
                        // Opening ready on the final handshake lets records run back to back.
                        rec_inc = 1'b1;
                        ready_o = ~fin_pending_q;
                        if (v_i && ~fin_pending_q && is_store) begin
                            state_n  = SEND_S;
                            cnt_n    = '0;
                            load_rec = 1'b1;
                        end else if (fin_pending_q || finish_i) begin
                            state_n   = TERM_S;
                            cnt_n     = '0;
                            load_term = 1'b1;
                        end else begin
                            state_n = IDLE_S;
                        end
                    end else begin
                        cnt_n      = cnt_q + 1'b1;
                        shift_flit = 1'b1;
                    end
                end
            end
            TERM_S: begin
                if (stream_ready_i) begin
                    if (last_flit)
                        state_n = DONE_S;
                    else
                        cnt_n = cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = DONE_S;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_stream_nbf_unloader.sv
// Randomized bench for mc_stream_nbf_unloader. A scoreboard turns every
// accepted store into its expected flits and checks the stream, record count,
// ready/done behaviour and stall stability against it.
module tb_mc_stream_nbf_unloader;

    localparam int A  = 28;
    localparam int D  = 32;
    localparam int X  = 6;
    localparam int Y  = 5;
    localparam int L  = 12;
    localparam int W  = 32;
    localparam int N  = 3;
    localparam int PL = (D > L) ? D : L;
    localparam int PW = A + 2 + (D >> 3) + PL + 2 * (X + Y);

    logic          clk = 1'b0;
    logic          reset_i;
    logic [PW-1:0] packet_i;
    logic          v_i;
    logic          ready_o;
    logic          finish_i;
    logic          done_o;
    logic          stream_v_o;
    logic [W-1:0]  stream_data_o;
    logic          stream_ready_i;
    logic [31:0]   records_o;

    mc_stream_nbf_unloader #(
        .addr_width_p(A), .data_width_p(D), .x_cord_width_p(X), .y_cord_width_p(Y),
        .load_id_width_p(L), .stream_data_width_p(W)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .packet_i(packet_i), .v_i(v_i), .ready_o(ready_o),
        .finish_i(finish_i), .done_o(done_o), .stream_v_o(stream_v_o),
        .stream_data_o(stream_data_o), .stream_ready_i(stream_ready_i), .records_o(records_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sink backpressure: 0 always ready, 1 ready one cycle in three, 2 random.
    always @(posedge clk) begin
        #1;
        case (mode)
            0:       stream_ready_i = 1'b1;
            1:       stream_ready_i = (cyc % 3 == 0);
            default: stream_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model state
    typedef struct { logic [W-1:0] d; bit last; } flit_t;
    flit_t         q[$];
    logic [W-1:0]  hs_log[$];
    int            hs_cyc[$];
    logic [31:0]   exp_rec;
    bit            fin, exp_done, stall, hs, er;
    int            tcnt;
    logic [W-1:0]  stall_d;

    // Expected flits of one store: the 80-bit record zero-padded to N*W bits.
    task automatic push_record(input logic [PW-1:0] p);
        logic [N*W-1:0] rec;
        logic [A-1:0]   addr;
        logic [PL-1:0]  pl;
        logic [Y-1:0]   sy;
        logic [X-1:0]   sx;
        flit_t          f;
        {addr, pl, sy, sx} = {p[PW-1 -: A], p[2*(X+Y) +: PL], p[X+Y+X +: Y], p[X+Y +: X]};
        rec = '0;
        rec[79:72] = 8'(sx);
        rec[71:64] = 8'(sy);
        rec[63:32] = 32'(addr);
        rec[31:0]  = 32'(pl[D-1:0]);
        for (int k = 0; k < N; k++) begin
            f.d    = rec[k*W +: W];
            f.last = (k == N - 1);
            q.push_back(f);
        end
    endtask

    // Scoreboard, sampled mid-cycle where inputs and outputs are settled.
    always @(negedge clk) begin
        if (reset_i) begin
            q.delete();
            exp_rec = 0; fin = 0; tcnt = 0; exp_done = 0; stall = 0;
        end else begin
            hs = stream_v_o && stream_ready_i;
            chk("records", records_o, exp_rec);
            chk("done", done_o, exp_done);
            if (stall) begin
                chk("stall_v", stream_v_o, 1);
                chk("stall_data", stream_data_o, stall_d);
            end
            if (exp_done)        er = 0;
            else if (stream_v_o) er = hs && q.size() > 0 && q[0].last && !fin;
            else                 er = !fin;
            chk("ready", ready_o, er);
            if (q.size() == 0 && !fin) chk("idle_v", stream_v_o, 0);
            if (hs) begin
                hs_log.push_back(stream_data_o);
                hs_cyc.push_back(cyc);
                if (q.size() > 0) begin
                    chk("flit", stream_data_o, q[0].d);
                    if (q[0].last) exp_rec++;
                    void'(q.pop_front());
                end else if (fin && tcnt < N) begin
                    chk("term_flit", stream_data_o, {W{1'b1}});
                    tcnt++;
                    if (tcnt == N) exp_done = 1;
                end else begin
                    chk("extra_flit", hs, 0);
                end
            end
            stall   = stream_v_o && !stream_ready_i;
            stall_d = stream_data_o;
            if (v_i && ready_o && !exp_done && packet_i[PW-A-1 -: 2] == 2'b01)
                push_record(packet_i);
            if (finish_i && !exp_done) fin = 1;
        end
    end

    function automatic logic [PW-1:0] mk_pkt(input logic [1:0] op, input logic [X-1:0] sx,
                                             input logic [Y-1:0] sy, input logic [A-1:0] addr,
                                             input logic [31:0] pl);
        logic [(D>>3)-1:0] opx = ($urandom);
        logic [Y-1:0]      dy  = Y'($urandom);
        logic [X-1:0]      dx  = X'($urandom);
        return {addr, op, opx, PL'(pl), sy, sx, dy, dx};
    endfunction

    // Present one packet at posedge+1 and hold it until it is taken.
    task automatic send_pkt(input logic [PW-1:0] p);
        int waited = 0;
        packet_i = p;
        v_i      = 1'b1;
        @(negedge clk);
        while (!ready_o && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!ready_o) chk("send_timeout", ready_o, 1);
        @(posedge clk); #1;
        v_i = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        @(negedge clk);
        while ((q.size() > 0 || stream_v_o) && waited < 500) begin
            waited++;
            @(negedge clk);
        end
        chk("drain", 64'(q.size()) + 64'(stream_v_o), 0);
        @(posedge clk); #1;
    endtask

    task automatic send_rand();
        logic [1:0] op = ($urandom_range(0, 9) < 7) ? 2'b01 : 2'($urandom_range(0, 3));
        send_pkt(mk_pkt(op, X'($urandom), Y'($urandom), A'($urandom), $urandom));
    endtask

    int base;

    initial begin
        reset_i = 1'b1; v_i = 1'b0; finish_i = 1'b0; packet_i = '0; stream_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("rst_stream_v", stream_v_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_records", records_o, 0);
        chk("rst_done", done_o, 0);
        @(posedge clk); #1;

        // Single store with known flits
        hs_log.delete(); hs_cyc.delete();
        send_pkt(mk_pkt(2'b01, 6'd2, 5'd3, 28'h1000, 32'hDEADBEEF));
        drain();
        chk("s1_nflits", hs_log.size(), 3);
        chk("s1_f0", hs_log[0], 32'hDEADBEEF);
        chk("s1_f1", hs_log[1], 32'h00001000);
        chk("s1_f2", hs_log[2], 32'h00000203);
        chk("s1_consec", hs_cyc[2] - hs_cyc[0], 2);
        chk("s1_records", records_o, 1);
        chk("s1_ready", ready_o, 1);

        // Back-to-back stores
        hs_log.delete(); hs_cyc.delete();
        for (int i = 0; i < 4; i++) send_rand_store();
        drain();
        chk("b2b_nflits", hs_log.size(), 12);
        chk("b2b_nobubble", hs_cyc[11] - hs_cyc[0], 11);
        chk("b2b_records", records_o, 5);

        // Backpressure
        mode = 1;
        for (int i = 0; i < 3; i++) send_rand_store();
        drain();
        mode = 0;

        // Non-store between two stores
        hs_log.delete(); hs_cyc.delete();
        base = exp_rec;
        send_rand_store();
        send_pkt(mk_pkt(2'b00, X'($urandom), Y'($urandom), A'($urandom), $urandom));
        send_rand_store();
        drain();
        chk("ns_nflits", hs_log.size(), 6);
        chk("ns_records", records_o, 32'(base + 2));

        // Random traffic with random backpressure
        mode = 2;
        for (int i = 0; i < 40; i++) begin
            send_rand();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        mode = 0;

        // Reset after flit 1 of a record
        hs_log.delete(); hs_cyc.delete();
        send_rand_store();
        while (hs_log.size() < 2 && cyc < 20000) @(posedge clk);
        #1 reset_i = 1'b1;
        @(posedge clk); #1 reset_i = 1'b0;
        @(negedge clk);
        chk("mr_stream_v", stream_v_o, 0);
        chk("mr_ready", ready_o, 1);
        chk("mr_records", records_o, 0);
        chk("mr_done", done_o, 0);
        @(posedge clk); #1;
        hs_log.delete(); hs_cyc.delete();
        send_pkt(mk_pkt(2'b01, 6'd1, 5'd1, 28'h20, 32'h12345678));
        drain();
        chk("mr_f0", hs_log[0], 32'h12345678);
        chk("mr_records2", records_o, 1);

        // Finish during flit 1
        hs_log.delete(); hs_cyc.delete();
        send_rand_store();
        @(posedge clk); #1 finish_i = 1'b1;
        @(posedge clk); #1 finish_i = 1'b0;
        for (int i = 0; i < 50 && !exp_done; i++) @(posedge clk);
        @(negedge clk);
        chk("fin_done", done_o, 1);
        chk("fin_nflits", hs_log.size(), 6);
        for (int k = 3; k < 6 && k < hs_log.size(); k++) chk("fin_term", hs_log[k], {W{1'b1}});
        chk("fin_consec", hs_cyc[hs_cyc.size()-1] - hs_cyc[0], 5);
        @(posedge clk); #1;
        packet_i = mk_pkt(2'b01, 6'd5, 5'd5, 28'h40, 32'hCAFE);
        v_i = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("done_ready", ready_o, 0);
            chk("done_stream_v", stream_v_o, 0);
        end
        @(posedge clk); #1 v_i = 1'b0;
        @(negedge clk);
        chk("done_hold", done_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic send_rand_store();
        send_pkt(mk_pkt(2'b01, X'($urandom), Y'($urandom), A'($urandom), $urandom));
    endtask

endmodule
